// File: rtl/adler32_checker.sv
// Receive-side Adler-32 checker: sums the payload, captures the 4-byte trailer
// through a sliding window, and reports the comparison one cycle after frame end.
module adler32_checker #(
    parameter int ADLER_MOD = 65521,
    parameter int LEN_W     = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             data_valid,
    input  logic [7:0]       data,
    input  logic             last_data,
    output logic             ready,
    output logic             check_valid,
    output logic             check_ok,
    output logic             length_err,
    output logic [31:0]      checksum,
    output logic [31:0]      rx_checksum,
    output logic [LEN_W-1:0] frame_len
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [16:0]      MOD17   = 17'(ADLER_MOD);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t            state_reg, state_next;
    logic [7:0]        win_reg [4];
    logic [2:0]        fill_reg;
    logic [15:0]       a_reg, b_reg;
    logic [LEN_W-1:0]  count_reg;

    logic              accept;
    logic              in_done;
    logic [16:0]       a_sum, b_sum;
    logic [15:0]       a_next, b_next;
    logic              len_err;
    logic [31:0]       sum_word, rx_word;

    assign accept  = data_valid & ready;
    assign in_done = (state_reg == DONE);

    // Only the byte falling out of the full window is payload.
    assign a_sum  = {1'b0, a_reg} + {9'b0, win_reg[0]};
    assign a_next = (a_sum >= MOD17) ? 16'(a_sum - MOD17) : a_sum[15:0];
    assign b_sum  = {1'b0, b_reg} + {1'b0, a_next};
    assign b_next = (b_sum >= MOD17) ? 16'(b_sum - MOD17) : b_sum[15:0];

    assign len_err  = (fill_reg < 3'd4);
    assign sum_word = {b_reg, a_reg};
    assign rx_word  = {win_reg[0], win_reg[1], win_reg[2], win_reg[3]};

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = last_data ? DONE : ACCUM;
            ACCUM:   if (accept && last_data) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_reg != DONE);
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_win
            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    win_reg[gi] <= 8'h00;
                end else if (in_done) begin
                    win_reg[gi] <= 8'h00;
                end else if (accept) begin
                    if (gi == 3) win_reg[gi] <= data;
                    else         win_reg[gi] <= win_reg[(gi + 1) % 4];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            fill_reg    <= 3'd0;
            a_reg       <= 16'd1;
            b_reg       <= 16'd0;
            count_reg   <= '0;
            check_valid <= 1'b0;
            check_ok    <= 1'b0;
            length_err  <= 1'b0;
            checksum    <= 32'h0;
            rx_checksum <= 32'h0;
            frame_len   <= '0;
        end else begin
            check_valid <= 1'b0;
            if (in_done) begin
                check_valid <= 1'b1;
                length_err  <= len_err;
                check_ok    <= ~len_err & (sum_word == rx_word);
                checksum    <= len_err ? 32'h0000_0001 : sum_word;
                rx_checksum <= len_err ? 32'h0 : rx_word;
                frame_len   <= len_err ? '0 : count_reg;
                fill_reg    <= 3'd0;
                a_reg       <= 16'd1;
                b_reg       <= 16'd0;
                count_reg   <= '0;
            end else if (accept) begin
                if (fill_reg == 3'd4) begin
                    a_reg <= a_next;
                    b_reg <= b_next;
                    if (count_reg != LEN_MAX) count_reg <= count_reg + 1'b1;
                end else begin
                    fill_reg <= fill_reg + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adler32_checker.sv
// Directed bench for adler32_checker: framed byte streams with hand-computed
// Adler-32 results, gaps, back-to-back frames, short frames and mid-frame reset.
module tb_adler32_checker;

    logic        clock;
    logic        rst;
    logic        data_valid;
    logic [7:0]  data;
    logic        last_data;
    logic        ready;
    logic        check_valid;
    logic        check_ok;
    logic        length_err;
    logic [31:0] checksum;
    logic [31:0] rx_checksum;
    logic [15:0] frame_len;

    int tests = 0;
    int fails = 0;

    adler32_checker #(.ADLER_MOD(65521), .LEN_W(16)) dut (
        .clock       (clock),
        .rst         (rst),
        .data_valid  (data_valid),
        .data        (data),
        .last_data   (last_data),
        .ready       (ready),
        .check_valid (check_valid),
        .check_ok    (check_ok),
        .length_err  (length_err),
        .checksum    (checksum),
        .rx_checksum (rx_checksum),
        .frame_len   (frame_len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one byte and waits (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        data       = b;
        last_data  = last;
        data_valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
        @(posedge clock); #1;
        data_valid = 1'b0;
        last_data  = 1'b0;
        $display("[TB] byte %h last=%0b accepted at %0t", b, last, $time);
    endtask

    // Sends n bytes of v, most significant byte first.
    task automatic send_vec(input logic [127:0] v, input int n, input int gap, input logic mark_last);
        for (int i = 0; i < n; i++) begin
            send_byte(v[8*(n-1-i) +: 8], mark_last && (i == n - 1));
            if (i != n - 1) repeat (gap) @(posedge clock);
            #1;
        end
    endtask

    // Call right after the last byte's accepting edge.
    task automatic check_result(input string tag, input logic ok, input logic lerr,
                                input logic [31:0] sum, input logic [31:0] rx,
                                input logic [15:0] len);
        @(negedge clock);
        chk({tag, ".ready_done"}, 32'(ready), 32'd0);
        chk({tag, ".cv_early"}, 32'(check_valid), 32'd0);
        @(negedge clock);
        chk({tag, ".cv"}, 32'(check_valid), 32'd1);
        chk({tag, ".ok"}, 32'(check_ok), 32'(ok));
        chk({tag, ".lerr"}, 32'(length_err), 32'(lerr));
        chk({tag, ".sum"}, checksum, sum);
        chk({tag, ".rx"}, rx_checksum, rx);
        chk({tag, ".len"}, 32'(frame_len), 32'(len));
        chk({tag, ".ready_again"}, 32'(ready), 32'd1);
        $display("[TB] %s: ok=%0b lerr=%0b sum=%h rx=%h len=%0d", tag,
                 check_ok, length_err, checksum, rx_checksum, frame_len);
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; data = 8'h00; last_data = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.cv", 32'(check_valid), 32'd0);
        chk("rst.ok", 32'(check_ok), 32'd0);
        chk("rst.lerr", 32'(length_err), 32'd0);
        chk("rst.sum", checksum, 32'h0);
        chk("rst.rx", rx_checksum, 32'h0);
        chk("rst.len", 32'(frame_len), 32'd0);
        rst = 1'b0;
        @(negedge clock);

        // T1: "Hello" with long gaps
        send_vec(128'h48656c6c6f058c01f5, 9, 50, 1'b1);
        check_result("T1", 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5, 16'd5);
        @(negedge clock);
        chk("T1.pulse_end", 32'(check_valid), 32'd0);
        chk("T1.hold_sum", checksum, 32'h058c01f5);

        // T2: "World" with wrong trailer, next frame right at edge k+2
        send_vec(128'h576f726c6406060208, 9, 0, 1'b1);
        check_result("T2", 1'b0, 1'b0, 32'h06060209, 32'h06060208, 16'd5);
        send_vec(128'h48656c6c6f058c01f5, 9, 0, 1'b1);
        check_result("T2next", 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5, 16'd5);

        // T3: empty payload
        send_vec(128'h00000001, 4, 0, 1'b1);
        check_result("T3", 1'b1, 1'b0, 32'h00000001, 32'h00000001, 16'd0);

        // T4: two-byte frame, then a clean frame
        send_vec(128'haabb, 2, 0, 1'b1);
        check_result("T4", 1'b0, 1'b1, 32'h00000001, 32'h0, 16'd0);
        send_vec(128'h576f726c6406060209, 9, 0, 1'b1);
        check_result("T4next", 1'b1, 1'b0, 32'h06060209, 32'h06060209, 16'd5);

        // T5: reset after three bytes of "Hello"
        send_vec(128'h48656c, 3, 0, 1'b0);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("T5.no_pulse", 32'(check_valid), 32'd0);
        end
        chk("T5.ready", 32'(ready), 32'd1);
        send_vec(128'h48656c6c6f058c01f5, 9, 0, 1'b1);
        check_result("T5", 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5, 16'd5);

        // T6: 257 x 0xFF exercises the modulo wrap of A
        for (int i = 0; i < 257; i++) send_byte(8'hFF, 1'b0);
        send_vec(128'h080F000F, 4, 0, 1'b1);
        // hold the next frame's first byte through the not-ready cycle
        data = 8'h48; last_data = 1'b0; data_valid = 1'b1;
        check_result("T6", 1'b1, 1'b0, 32'h080F000F, 32'h080F000F, 16'd257);
        @(posedge clock); #1;
        data_valid = 1'b0;
        send_vec(128'h656c6c6f058c01f5, 8, 0, 1'b1);
        check_result("T6next", 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5, 16'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
